// File: rtl/rename_map_pkg.sv
// Shared sizing constants and types for the register rename map and its checkpoint ring.
package rename_pkg;

  localparam int unsigned ARCH_REGS = 16;
  localparam int unsigned PHYS_REGS = 32;
  localparam int unsigned WIDTH     = 2;
  localparam int unsigned NCKPT     = 4;

  localparam int unsigned ARW = $clog2(ARCH_REGS);
  localparam int unsigned PRW = $clog2(PHYS_REGS);
  localparam int unsigned CKW = $clog2(NCKPT);

  typedef logic [ARW-1:0] areg_t;
  typedef logic [PRW-1:0] preg_t;
  typedef logic [CKW-1:0] ckid_t;
  typedef preg_t [ARCH_REGS-1:0] map_t;

  // Reset mapping: every architectural register starts on the physical tag of the same index.
  function automatic map_t identity_map();
    map_t m;
    for (int unsigned i = 0; i < ARCH_REGS; i++) begin
      m[i] = preg_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_map_if.sv
// Rename group, checkpoint and recovery signals between decode/free list and the rename map.
interface rename_map_if
  import rename_pkg::*;
();

  logic [WIDTH-1:0] rn_valid;
  areg_t [WIDTH-1:0] rn_src_a;
  areg_t [WIDTH-1:0] rn_src_b;
  areg_t [WIDTH-1:0] rn_dst;
  logic [WIDTH-1:0] rn_dst_we;
  preg_t [WIDTH-1:0] rn_new_pdst;
  logic              rn_ready;
  preg_t [WIDTH-1:0] rn_psrc_a;
  preg_t [WIDTH-1:0] rn_psrc_b;
  preg_t [WIDTH-1:0] rn_old_pdst;

  logic  ckpt_req;
  ckid_t ckpt_id;
  logic  ckpt_full;
  logic  ckpt_release;
  logic  restore_valid;
  ckid_t restore_id;

  modport master (
    output rn_valid, rn_src_a, rn_src_b, rn_dst, rn_dst_we, rn_new_pdst,
    output ckpt_req, ckpt_release, restore_valid, restore_id,
    input  rn_ready, rn_psrc_a, rn_psrc_b, rn_old_pdst, ckpt_id, ckpt_full
  );

  modport slave (
    input  rn_valid, rn_src_a, rn_src_b, rn_dst, rn_dst_we, rn_new_pdst,
    input  ckpt_req, ckpt_release, restore_valid, restore_id,
    output rn_ready, rn_psrc_a, rn_psrc_b, rn_old_pdst, ckpt_id, ckpt_full
  );

endinterface

// File: rtl/rename_ckpt_ring.sv
// Ring of map snapshots with head/tail/count; restore rewinds tail and drops younger entries.
module rename_ckpt_ring
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  alloc,
  input  map_t  alloc_data,
  input  logic  release_req,
  input  logic  restore,
  input  ckid_t restore_id,
  output map_t  snap_out,
  output logic  full,
  output ckid_t tail
);

  localparam int unsigned CNTW = CKW + 1;
  typedef logic [CNTW-1:0] cnt_t;

  ckid_t head_q;
  ckid_t tail_q;
  cnt_t  count_q;
  map_t  snap_q [NCKPT];
  logic  rel_eff;
  logic  alloc_eff;

  assign rel_eff   = release_req && (count_q != '0) && !restore;
  assign alloc_eff = alloc && !restore;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (restore) begin
      // Restored slot and everything younger become free again.
      tail_q  <= restore_id;
      count_q <= {1'b0, ckid_t'(restore_id - head_q)};
    end else begin
      if (alloc_eff) begin
        tail_q <= ckid_t'(tail_q + 1'b1);
      end
      if (rel_eff) begin
        head_q <= ckid_t'(head_q + 1'b1);
      end
      count_q <= count_q + cnt_t'(alloc_eff) - cnt_t'(rel_eff);
    end
  end

  // Snapshot storage carries no reset; only live slots are ever read back.
  always_ff @(posedge clk) begin
    if (!rst && alloc_eff) begin
      snap_q[tail_q] <= alloc_data;
    end
  end

  assign snap_out = snap_q[restore_id];
  assign full     = (count_q == cnt_t'(NCKPT));
  assign tail     = tail_q;

endmodule

// File: rtl/rename_map.sv
// Register rename map: bypassed lookup for a rename group, map update, and checkpoint-based recovery.
module rename_map
  import rename_pkg::*;
(
  input logic       clk,
  input logic       rst,
  rename_map_if.slave bus
);

  map_t  map_q;
  map_t  map_next;
  map_t  snap_out;
  logic  full;
  ckid_t tail;
  logic  ready;
  logic  fire;

  preg_t [WIDTH-1:0] psrc_a;
  preg_t [WIDTH-1:0] psrc_b;
  preg_t [WIDTH-1:0] old_pdst;

  assign ready = !bus.restore_valid && !(bus.ckpt_req && full);
  assign fire  = (|bus.rn_valid) && ready;

  // Older slots in the group override the map; the highest matching older slot wins.
  always_comb begin
    psrc_a   = '0;
    psrc_b   = '0;
    old_pdst = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      psrc_a[i]   = map_q[bus.rn_src_a[i]];
      psrc_b[i]   = map_q[bus.rn_src_b[i]];
      old_pdst[i] = map_q[bus.rn_dst[i]];
      for (int unsigned j = 0; j < i; j++) begin
        if (bus.rn_valid[j] && bus.rn_dst_we[j]) begin
          if (bus.rn_dst[j] == bus.rn_src_a[i]) psrc_a[i]   = bus.rn_new_pdst[j];
          if (bus.rn_dst[j] == bus.rn_src_b[i]) psrc_b[i]   = bus.rn_new_pdst[j];
          if (bus.rn_dst[j] == bus.rn_dst[i])   old_pdst[i] = bus.rn_new_pdst[j];
        end
      end
    end
  end

  // Ascending slot order makes the highest slot win on a shared destination.
  always_comb begin
    map_next = map_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.rn_valid[i] && bus.rn_dst_we[i]) begin
        map_next[bus.rn_dst[i]] = bus.rn_new_pdst[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q <= identity_map();
    end else if (bus.restore_valid) begin
      map_q <= snap_out;
    end else if (fire) begin
      map_q <= map_next;
    end
  end

  rename_ckpt_ring u_ring (
    .clk         (clk),
    .rst         (rst),
    .alloc       (fire && bus.ckpt_req),
    .alloc_data  (map_next),
    .release_req (bus.ckpt_release),
    .restore     (bus.restore_valid),
    .restore_id  (bus.restore_id),
    .snap_out    (snap_out),
    .full        (full),
    .tail        (tail)
  );

  assign bus.rn_ready    = ready;
  assign bus.rn_psrc_a   = psrc_a;
  assign bus.rn_psrc_b   = psrc_b;
  assign bus.rn_old_pdst = old_pdst;
  assign bus.ckpt_id     = tail;
  assign bus.ckpt_full   = full;

endmodule
